// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler
// Launches capture runs, waits for completion, and swaps the two feature-map
// BRAM banks only at a tiler start-of-frame so the display never tears.
// Port A (capture writer) addresses bank wr_bank; port B (tiler) addresses
// the other bank.
// Optional feature macro: SCHED_TIMEOUT_EN builds the RUN timeout counter and
// the ERROR state. Without it RUN waits indefinitely and timeout_err is 0.
//
// Handshake note: cap_start, cap_done and sof are single-cycle pulses with no
// back-pressure; a pulse is acted on only in the state that expects it and is
// otherwise ignored.
module conv_frame_scheduler #(
    parameter int BANK_AWIDTH    = 11,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   out_stream_aclk,
    input  logic                   periph_reset,
    input  logic                   start_req,
    input  logic                   continuous,
    input  logic                   clear_err,
    output logic                   cap_start,
    input  logic                   cap_done,
    input  logic [BANK_AWIDTH-1:0] cap_addr,
    input  logic [BANK_AWIDTH-1:0] tiler_addr,
    input  logic                   sof,
    output logic [BANK_AWIDTH:0]   bram_addr_a,
    output logic [BANK_AWIDTH:0]   bram_addr_b,
    output logic                   busy,
    output logic                   frame_ready,
    output logic                   timeout_err,
    output logic [CNT_WIDTH-1:0]   run_count,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_RUN       = 3'd2,
        S_SWAP_WAIT = 3'd3,
        S_ERROR     = 3'd4
    } state_t;

    state_t state;
    logic   wr_bank;
    logic   pending;
    logic   start_prev;
    logic   start_rise;
    logic   tmo_hit;

    assign start_rise = start_req & ~start_prev;

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;

    // RUN-cycle counter: zeroed in LAUNCH so it starts at 0 on RUN entry.
    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            tmo_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            tmo_cnt <= '0;
        end else if (state == S_RUN) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit     = (state == S_RUN) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = (state == S_ERROR);
`else
    logic tmo_unused;
    assign tmo_unused  = (TIMEOUT_CYCLES != 0);
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Registered copy of start_req for rising-edge detection.
    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) start_prev <= 1'b0;
        else              start_prev <= start_req;
    end

    // Main sequencer: launch, run, swap at sof, plus one-deep pending request.
    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state       <= S_IDLE;
            wr_bank     <= 1'b0;
            pending     <= 1'b0;
            frame_ready <= 1'b0;
            run_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_rise || continuous) state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    if (start_rise) pending <= 1'b1;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (start_rise) pending <= 1'b1;
                    // Completion takes priority over a coincident timeout.
                    if (cap_done)     state <= S_SWAP_WAIT;
                    else if (tmo_hit) state <= S_ERROR;
                end
                S_SWAP_WAIT: begin
                    if (sof) begin
                        wr_bank     <= ~wr_bank;
                        frame_ready <= 1'b1;
                        run_count   <= run_count + CNT_WIDTH'(1);
                        pending     <= 1'b0;
                        state       <= (continuous || pending) ? S_LAUNCH : S_IDLE;
                    end else if (start_rise) begin
                        pending <= 1'b1;
                    end
                end
                S_ERROR: begin
                    pending <= 1'b0;
                    if (clear_err) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cap_start   = (state == S_LAUNCH);
    assign busy        = (state == S_LAUNCH) || (state == S_RUN) || (state == S_SWAP_WAIT);
    assign state_dbg   = state;
    assign bram_addr_a = {wr_bank, cap_addr};
    assign bram_addr_b = {~wr_bank, tiler_addr};

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Directed bench for conv_frame_scheduler: reset values, single run with bank
// swap, continuous mode, pending request, timeout/error and mid-run reset.
module tb_conv_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_req = 1'b0;
    logic        continuous = 1'b0;
    logic        clear_err = 1'b0;
    logic        cap_start;
    logic        cap_done = 1'b0;
    logic [10:0] cap_addr = 11'h123;
    logic [10:0] tiler_addr = 11'h456;
    logic        sof = 1'b0;
    logic [11:0] bram_addr_a;
    logic [11:0] bram_addr_b;
    logic        busy;
    logic        frame_ready;
    logic        timeout_err;
    logic [15:0] run_count;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    conv_frame_scheduler #(
        .BANK_AWIDTH(11),
        .TIMEOUT_CYCLES(100),
        .CNT_WIDTH(16)
    ) dut (
        .out_stream_aclk(clk),
        .periph_reset(rst),
        .start_req(start_req),
        .continuous(continuous),
        .clear_err(clear_err),
        .cap_start(cap_start),
        .cap_done(cap_done),
        .cap_addr(cap_addr),
        .tiler_addr(tiler_addr),
        .sof(sof),
        .bram_addr_a(bram_addr_a),
        .bram_addr_b(bram_addr_b),
        .busy(busy),
        .frame_ready(frame_ready),
        .timeout_err(timeout_err),
        .run_count(run_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        tick();
        tick();
        n_checks++; if (cap_start !== 1'b0) begin n_fail++; $display("FAIL rst_cap_start got %b exp 0", cap_start); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL rst_frame_ready got %b exp 0", frame_ready); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err got %b exp 0", timeout_err); end
        n_checks++; if (run_count !== 16'd0) begin n_fail++; $display("FAIL rst_run_count got %0d exp 0", run_count); end
        n_checks++; if (bram_addr_a !== 12'h123) begin n_fail++; $display("FAIL rst_addr_a got %h exp 123", bram_addr_a); end
        n_checks++; if (bram_addr_b !== 12'hC56) begin n_fail++; $display("FAIL rst_addr_b got %h exp c56", bram_addr_b); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_run();
        repeat (9) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b exp 0", busy); end
        start_req = 1'b1;
        tick();
        n_checks++; if (cap_start !== 1'b1) begin n_fail++; $display("FAIL single_cap_start got %b exp 1", cap_start); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_launch got %b exp 1", busy); end
        tick();
        n_checks++; if (cap_start !== 1'b0) begin n_fail++; $display("FAIL single_cap_start_width got %b exp 0", cap_start); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_run got %b exp 1", busy); end
        start_req = 1'b0;
        repeat (5) tick();
        sof = 1'b1; tick(); sof = 1'b0;
        n_checks++; if (run_count !== 16'd0) begin n_fail++; $display("FAIL sof_in_run got %0d exp 0", run_count); end
        repeat (30) tick();
        cap_done = 1'b1; sof = 1'b1; tick(); cap_done = 1'b0; sof = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_sof_busy got %b exp 1", busy); end
        n_checks++; if (run_count !== 16'd0) begin n_fail++; $display("FAIL done_sof_no_swap got %0d exp 0", run_count); end
        n_checks++; if (bram_addr_a !== 12'h123) begin n_fail++; $display("FAIL done_sof_addr_a got %h exp 123", bram_addr_a); end
        repeat (29) tick();
        sof = 1'b1; tick(); sof = 1'b0;
        n_checks++; if (run_count !== 16'd1) begin n_fail++; $display("FAIL swap_run_count got %0d exp 1", run_count); end
        n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL swap_frame_ready got %b exp 1", frame_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swap_busy got %b exp 0", busy); end
        n_checks++; if (bram_addr_a !== 12'h923) begin n_fail++; $display("FAIL swap_addr_a got %h exp 923", bram_addr_a); end
        n_checks++; if (bram_addr_b !== 12'h456) begin n_fail++; $display("FAIL swap_addr_b got %h exp 456", bram_addr_b); end
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_in_idle got %b exp 0", busy); end
        sof = 1'b1; tick(); sof = 1'b0;
        n_checks++; if (bram_addr_b !== 12'h456) begin n_fail++; $display("FAIL sof_in_idle got %h exp 456", bram_addr_b); end
    endtask

    task automatic test_continuous();
        rst = 1'b1;
        #1;
        n_checks++; if (bram_addr_a !== 12'h123) begin n_fail++; $display("FAIL cont_reset_addr_a got %h exp 123", bram_addr_a); end
        tick();
        rst = 1'b0;
        continuous = 1'b1;
        tick();
        n_checks++; if (cap_start !== 1'b1) begin n_fail++; $display("FAIL cont_first_launch got %b exp 1", cap_start); end
        for (int i = 0; i < 3; i++) begin
            logic exp_bank;
            logic exp_start;
            exp_bank  = (i % 2 == 0) ? 1'b1 : 1'b0;
            exp_start = (i < 2) ? 1'b1 : 1'b0;
            tick();
            n_checks++; if (cap_start !== 1'b0) begin n_fail++; $display("FAIL cont_run_%0d cap_start got %b exp 0", i, cap_start); end
            repeat (4) tick();
            cap_done = 1'b1; tick(); cap_done = 1'b0;
            repeat (3) tick();
            if (i == 2) continuous = 1'b0;
            sof = 1'b1; tick(); sof = 1'b0;
            n_checks++; if (run_count !== 16'(i + 1)) begin n_fail++; $display("FAIL cont_count_%0d got %0d exp %0d", i, run_count, i + 1); end
            n_checks++; if (bram_addr_a[11] !== exp_bank) begin n_fail++; $display("FAIL cont_bank_%0d got %b exp %b", i, bram_addr_a[11], exp_bank); end
            n_checks++; if (cap_start !== exp_start) begin n_fail++; $display("FAIL cont_relaunch_%0d got %b exp %b", i, cap_start, exp_start); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_pending();
        start_req = 1'b1; tick();
        n_checks++; if (cap_start !== 1'b1) begin n_fail++; $display("FAIL pend_launch got %b exp 1", cap_start); end
        start_req = 1'b0; tick();
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        tick();
        sof = 1'b1; tick(); sof = 1'b0;
        n_checks++; if (run_count !== 16'd4) begin n_fail++; $display("FAIL pend_count1 got %0d exp 4", run_count); end
        n_checks++; if (cap_start !== 1'b1) begin n_fail++; $display("FAIL pend_extra_launch got %b exp 1", cap_start); end
        tick();
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        sof = 1'b1; tick(); sof = 1'b0;
        n_checks++; if (run_count !== 16'd5) begin n_fail++; $display("FAIL pend_count2 got %0d exp 5", run_count); end
        n_checks++; if (cap_start !== 1'b0) begin n_fail++; $display("FAIL pend_dropped got %b exp 0", cap_start); end
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_idle_busy got %b exp 0", busy); end
        n_checks++; if (bram_addr_a !== 12'h923) begin n_fail++; $display("FAIL pend_bank got %h exp 923", bram_addr_a); end
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        repeat (97) tick();
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b exp 0", timeout_err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_last got %b exp 1", busy); end
        tick();
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b exp 1", timeout_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b exp 0", busy); end
        n_checks++; if (bram_addr_a !== 12'h923) begin n_fail++; $display("FAIL tmo_bank_held got %h exp 923", bram_addr_a); end
        n_checks++; if (run_count !== 16'd5) begin n_fail++; $display("FAIL tmo_count got %0d exp 5", run_count); end
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_edge_ignored got %b exp 1", timeout_err); end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear got %b exp 0", timeout_err); end
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_pending_cleared got %b exp 0", busy); end
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        repeat (99) tick();
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_done_wins_err got %b exp 0", timeout_err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_done_wins_busy got %b exp 1", busy); end
        sof = 1'b1; tick(); sof = 1'b0;
        n_checks++; if (run_count !== 16'd6) begin n_fail++; $display("FAIL tmo_swap_count got %0d exp 6", run_count); end
        n_checks++; if (bram_addr_a !== 12'h123) begin n_fail++; $display("FAIL tmo_swap_bank got %h exp 123", bram_addr_a); end
    endtask
`else
    task automatic test_timeout();
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        repeat (150) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL notmo_busy got %b exp 1", busy); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL notmo_err got %b exp 0", timeout_err); end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL notmo_clear_ignored got %b exp 1", busy); end
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        sof = 1'b1; tick(); sof = 1'b0;
        n_checks++; if (run_count !== 16'd6) begin n_fail++; $display("FAIL notmo_swap_count got %0d exp 6", run_count); end
        n_checks++; if (bram_addr_a !== 12'h123) begin n_fail++; $display("FAIL notmo_swap_bank got %h exp 123", bram_addr_a); end
    endtask
`endif

    task automatic test_reset_mid_run();
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        sof = 1'b1; tick(); sof = 1'b0;
        n_checks++; if (run_count !== 16'd7) begin n_fail++; $display("FAIL mid_pre_count got %0d exp 7", run_count); end
        n_checks++; if (bram_addr_a !== 12'h923) begin n_fail++; $display("FAIL mid_pre_bank got %h exp 923", bram_addr_a); end
        start_req = 1'b1; tick();
        start_req = 1'b0; tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_run_busy got %b exp 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bram_addr_a !== 12'h123) begin n_fail++; $display("FAIL mid_addr_a got %h exp 123", bram_addr_a); end
        n_checks++; if (bram_addr_b !== 12'hC56) begin n_fail++; $display("FAIL mid_addr_b got %h exp c56", bram_addr_b); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_checks++; if (cap_start !== 1'b0) begin n_fail++; $display("FAIL mid_cap_start got %b exp 0", cap_start); end
        n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL mid_frame_ready got %b exp 0", frame_ready); end
        n_checks++; if (run_count !== 16'd0) begin n_fail++; $display("FAIL mid_run_count got %0d exp 0", run_count); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL mid_timeout_err got %b exp 0", timeout_err); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_release got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_continuous();
        test_pending();
        test_timeout();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
